neuron_o_loader: RTL

NEURON_O_LOADER -- requirements
Module: neuron_o_loader

---
 rtl/neuron_pkg.sv | 14 +
 rtl/neuron_o_loader_if.sv | 32 +++
 rtl/pair_buf.sv | 64 ++++++
 rtl/neuron_o_loader.sv | 124 ++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the output-neuron operand loader: default data width
// and the load sequencer state encoding.
package neuron_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WANT_A2 = 2'd1,
        WANT_W2 = 2'd2,
        WANT_B  = 2'd3
    } load_state_t;

endpackage

// File: rtl/neuron_o_loader_if.sv
// Word-stream input and operand-set output bundle of the output-neuron loader.
// The loader itself uses the slave view; the producer/consumer side uses master.
interface neuron_o_loader_if
    import neuron_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_is_param;

    logic [WIDTH-1:0] w_1;
    logic [WIDTH-1:0] w_2;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_1;
    logic [WIDTH-1:0] a_2;
    logic             op_valid;
    logic             op_ready;

    modport master (
        output in_valid, in_data, in_is_param, op_ready,
        input  in_ready, w_1, w_2, b, a_1, a_2, op_valid
    );

    modport slave (
        input  in_valid, in_data, in_is_param, op_ready,
        output in_ready, w_1, w_2, b, a_1, a_2, op_valid
    );

endinterface

// File: rtl/pair_buf.sv
// Two-entry activation pair buffer: an output register that drives the operand
// bus plus one staging entry that refills it on the draining cycle.
module pair_buf
    import neuron_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_a1,
    input  logic [WIDTH-1:0] push_a2,
    input  logic             pop,
    output logic [WIDTH-1:0] out_a1,
    output logic [WIDTH-1:0] out_a2,
    output logic             out_valid,
    output logic             full
);

    logic [WIDTH-1:0] st_a1;
    logic [WIDTH-1:0] st_a2;
    logic             st_valid;

    assign full = st_valid;

    // A drain promotes staging first so pairs leave strictly in arrival order
    always_ff @(posedge clk) begin
        if (rst) begin
            out_a1    <= '0;
            out_a2    <= '0;
            out_valid <= 1'b0;
            st_a1     <= '0;
            st_a2     <= '0;
            st_valid  <= 1'b0;
        end else if (pop) begin
            if (st_valid) begin
                out_a1 <= st_a1;
                out_a2 <= st_a2;
                if (push) begin
                    st_a1 <= push_a1;
                    st_a2 <= push_a2;
                end else begin
                    st_valid <= 1'b0;
                end
            end else if (push) begin
                out_a1 <= push_a1;
                out_a2 <= push_a2;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            if (!out_valid) begin
                out_a1    <= push_a1;
                out_a2    <= push_a2;
                out_valid <= 1'b1;
            end else begin
                st_a1    <= push_a1;
                st_a2    <= push_a2;
                st_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/neuron_o_loader.sv
// Output-neuron operand loader: splits one word stream into parameter triples
// (w_1, w_2, b) and activation pairs, and presents them as one operand set.
module neuron_o_loader
    import neuron_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    neuron_o_loader_if.slave  bus,
    output logic              params_loaded,
    output logic              seq_err,
    output logic [15:0]       op_count
);

    load_state_t      state;
    logic [WIDTH-1:0] sh_w1, sh_w2, a1_hold;
    logic [WIDTH-1:0] w1_q, w2_q, b_q;
    logic [WIDTH-1:0] pb_a1, pb_a2;
    logic [WIDTH-1:0] data;
    logic             pb_valid, stage_full;
    logic             is_param, accept, push, pop;

    assign data     = bus.in_data;
    assign is_param = bus.in_is_param;

    // Parameters are held back while an operand set is pending so it never changes under the consumer
    assign bus.in_ready = !rst && !stage_full && (is_param ? !pb_valid : params_loaded);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && !is_param && (state == WANT_A2);
    assign pop          = !rst && pb_valid && bus.op_ready;

    assign bus.w_1      = w1_q;
    assign bus.w_2      = w2_q;
    assign bus.b        = b_q;
    assign bus.a_1      = pb_a1;
    assign bus.a_2      = pb_a2;
    assign bus.op_valid = pb_valid;

    // A word of the other kind aborts the partial sequence and becomes the first word of a new one
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sh_w1         <= '0;
            sh_w2         <= '0;
            a1_hold       <= '0;
            w1_q          <= '0;
            w2_q          <= '0;
            b_q           <= '0;
            params_loaded <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (is_param) begin
                            sh_w1 <= data;
                            state <= WANT_W2;
                        end else begin
                            a1_hold <= data;
                            state   <= WANT_A2;
                        end
                    end
                    WANT_A2: begin
                        if (is_param) begin
                            seq_err <= 1'b1;
                            sh_w1   <= data;
                            state   <= WANT_W2;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WANT_W2: begin
                        if (!is_param) begin
                            seq_err <= 1'b1;
                            a1_hold <= data;
                            state   <= WANT_A2;
                        end else begin
                            sh_w2 <= data;
                            state <= WANT_B;
                        end
                    end
                    WANT_B: begin
                        if (!is_param) begin
                            seq_err <= 1'b1;
                            a1_hold <= data;
                            state   <= WANT_A2;
                        end else begin
                            w1_q          <= sh_w1;
                            w2_q          <= sh_w2;
                            b_q           <= data;
                            params_loaded <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (pop) begin
            op_count <= op_count + 16'd1;
        end
    end

    pair_buf #(.WIDTH(WIDTH)) u_pair_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_a1   (a1_hold),
        .push_a2   (data),
        .pop       (pop),
        .out_a1    (pb_a1),
        .out_a2    (pb_a2),
        .out_valid (pb_valid),
        .full      (stage_full)
    );

endmodule
